// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter -- round-robin arbiter that multiplexes NUM_PORTS upstream
// cbus burst masters onto one downstream cbus port.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous, active-high reset
//   reqs       upstream burst requests, index 0..NUM_PORTS-1
//   resps      upstream responses; only the bus owner sees oresp, others zero
//   oreq       downstream burst request (owner's request passed through)
//   oresp      downstream response
//   grant_id   index of the owning port, meaningful only while busy=1
//   busy       1 while a burst is owned by a port
//   proto_err  one-cycle pulse after a burst protocol violation
//
// The len field encodes beats-1 (MLEN4 = 3), so the final beat of a
// well-formed burst arrives while the beat counter equals len.

package cbus_pkg;

    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } cbus_len_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        reqs  [NUM_PORTS],
    output cbus_resp_t       resps [NUM_PORTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic [SEL_W-1:0] grant_id,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [SEL_W-1:0] prio_ptr;
    logic [SEL_W-1:0] prio_nxt;
    logic [SEL_W-1:0] grant_nxt;
    logic [SEL_W-1:0] ptr_inc;
    logic [SEL_W-1:0] pick;
    logic             pick_valid;
    logic [7:0]       beat_cnt;
    logic [7:0]       beat_nxt;
    logic             err_nxt;
    cbus_req_t        owner;

    assign owner = reqs[grant_id];

    // Explicit wrap so non-power-of-two port counts stay in range.
    assign ptr_inc = (grant_id == SEL_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;

    // First valid port at or after prio_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned      idx;
        logic [SEL_W-1:0] idx_s;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        idx_s      = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx   = (32'(prio_ptr) + i) % NUM_PORTS;
            idx_s = SEL_W'(idx);
            if (!pick_valid && reqs[idx_s].valid) begin
                pick_valid = 1'b1;
                pick       = idx_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        prio_nxt  = prio_ptr;
        beat_nxt  = beat_cnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (pick_valid) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!owner.valid) begin
                    // Abandoned by the owner: it keeps its priority.
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (oresp.ready) begin
                    beat_nxt = beat_cnt + 8'd1;
                    if (oresp.last) begin
                        err_nxt   = (beat_cnt != owner.len);
                        state_nxt = IDLE;
                        prio_nxt  = ptr_inc;
                    end else if (beat_cnt == owner.len) begin
                        // Overrun: the beat that should have been last was not.
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                        prio_nxt  = ptr_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on state and reqs only on the oreq side, so there is
    // no combinational path from oresp to oreq.
    always_comb begin
        oreq  = '0;
        busy  = 1'b0;
        resps = '{default: '0};
        if (state == BUSY) begin
            busy            = 1'b1;
            oreq            = owner;
            resps[grant_id] = oresp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= '0;
            prio_ptr  <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            prio_ptr  <= prio_nxt;
            beat_cnt  <= beat_nxt;
            proto_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int MAXP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    cbus_req_t  req [MAXP];
    cbus_resp_t oresp;
    int         sel_n;

    cbus_req_t  r2 [2];
    cbus_req_t  r3 [3];
    cbus_req_t  r4 [4];
    cbus_resp_t s2 [2];
    cbus_resp_t s3 [3];
    cbus_resp_t s4 [4];
    cbus_req_t  o2, o3, o4;
    logic [0:0] g2;
    logic [1:0] g3, g4;
    logic       b2, b3, b4, e2, e3, e4;

    always_comb begin
        for (int i = 0; i < 2; i++) r2[i] = req[i];
        for (int i = 0; i < 3; i++) r3[i] = req[i];
        for (int i = 0; i < 4; i++) r4[i] = req[i];
    end

    cbus_rr_arbiter #(.NUM_PORTS(2)) u_arb2 (
        .clk(clk), .reset(reset), .reqs(r2), .resps(s2), .oreq(o2),
        .oresp(oresp), .grant_id(g2), .busy(b2), .proto_err(e2)
    );
    cbus_rr_arbiter #(.NUM_PORTS(3)) u_arb3 (
        .clk(clk), .reset(reset), .reqs(r3), .resps(s3), .oreq(o3),
        .oresp(oresp), .grant_id(g3), .busy(b3), .proto_err(e3)
    );
    cbus_rr_arbiter #(.NUM_PORTS(4)) u_arb4 (
        .clk(clk), .reset(reset), .reqs(r4), .resps(s4), .oreq(o4),
        .oresp(oresp), .grant_id(g4), .busy(b4), .proto_err(e4)
    );

    cbus_req_t  cur_oreq;
    cbus_resp_t cur_resps [MAXP];
    logic       cur_busy, cur_err;
    int         cur_gid;

    always_comb begin
        cur_oreq = '0;
        cur_busy = 1'b0;
        cur_err  = 1'b0;
        cur_gid  = 0;
        for (int i = 0; i < MAXP; i++) cur_resps[i] = '0;
        case (sel_n)
            2: begin
                cur_oreq = o2; cur_busy = b2; cur_err = e2; cur_gid = int'(g2);
                for (int i = 0; i < 2; i++) cur_resps[i] = s2[i];
            end
            3: begin
                cur_oreq = o3; cur_busy = b3; cur_err = e3; cur_gid = int'(g3);
                for (int i = 0; i < 3; i++) cur_resps[i] = s3[i];
            end
            default: begin
                cur_oreq = o4; cur_busy = b4; cur_err = e4; cur_gid = int'(g4);
                for (int i = 0; i < 4; i++) cur_resps[i] = s4[i];
            end
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;
    int first_cyc;

    int         gq [$];
    cbus_req_t  aq [$];
    cbus_resp_t dq [$];

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.write = addr[4];
        r.addr  = addr;
        r.len   = len;
        r.wdata = ~addr;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < MAXP; i++) req[i] = '0;
        oresp = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (cur_busy === 1'b1) ok = 1'b1;
        end
    endtask

    // Serves nb well-formed bursts of nbeats each; expected owners and
    // requests come from gq/aq, filled by the caller.
    task automatic test_bursts(input int nb, input int nbeats, input int budget);
        int         done, beat, cyc, last_cyc, g;
        bit         inb, after_last, bad;
        cbus_req_t  want_req;
        cbus_resp_t beat_r, want_r, zr;
        done = 0; beat = 0; cyc = 0; last_cyc = 0; g = 0;
        inb = 1'b0; after_last = 1'b0; first_cyc = -1; zr = '0;
        while (done < nb && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (after_last) begin
                after_last = 1'b0;
                n_tests++;
                if (cur_busy !== 1'b0 || cur_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_after_burst: busy=%b err=%b, want busy=0 err=0", cur_busy, cur_err);
                end
            end
            if (!inb && cur_busy === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                n_tests++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: got grant_id=%0d, want no grant", cur_gid);
                end else begin
                    g        = gq.pop_front();
                    want_req = aq.pop_front();
                    if (cur_gid != g || cur_oreq !== want_req) begin
                        n_fail++;
                        $display("FAIL grant: got id=%0d oreq=%h, want id=%0d oreq=%h", cur_gid, cur_oreq, g, want_req);
                    end
                end
                if (done > 0) begin
                    n_tests++;
                    if (cyc - last_cyc != 2) begin
                        n_fail++;
                        $display("FAIL idle_gap: got %0d idle cycles, want 1", cyc - last_cyc - 1);
                    end
                end
                inb  = 1'b1;
                beat = 0;
            end
            if (inb) begin
                beat_r = mk_resp(1'b1, beat == nbeats - 1, $urandom());
                oresp  = beat_r;
                dq.push_back(beat_r);
                #1;
                want_r = dq.pop_front();
                bad    = 1'b0;
                for (int p = 0; p < MAXP; p++)
                    if (cur_resps[p] !== ((p == g) ? want_r : zr)) bad = 1'b1;
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL route beat %0d: got resps[%0d]=%h, want %h with other ports zero", beat, g, cur_resps[g], want_r);
                end
                beat++;
                if (beat == nbeats) begin
                    inb        = 1'b0;
                    done++;
                    last_cyc   = cyc;
                    after_last = 1'b1;
                end
            end else begin
                oresp = '0;
            end
        end
        n_tests++;
        if (done != nb) begin
            n_fail++;
            $display("FAIL bursts_done: got %0d bursts, want %0d", done, nb);
        end
    endtask

    task automatic test_reset();
        int  sels [3] = '{2, 3, 4};
        bit  bad;
        for (int i = 0; i < MAXP; i++) req[i] = mk_req(32'h100 * (i + 1), MLEN4);
        oresp = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        foreach (sels[k]) begin
            sel_n = sels[k];
            #1;
            n_tests++;
            if (cur_busy !== 1'b0 || cur_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags n=%0d: busy=%b err=%b, want 0 0", sel_n, cur_busy, cur_err);
            end
            n_tests++;
            if (cur_oreq !== '0 || cur_gid != 0) begin
                n_fail++;
                $display("FAIL reset_oreq n=%0d: oreq=%h gid=%0d, want 0 0", sel_n, cur_oreq, cur_gid);
            end
            bad = 1'b0;
            for (int p = 0; p < MAXP; p++) if (cur_resps[p] !== '0) bad = 1'b1;
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL reset_resps n=%0d: resps[0]=%h, want all zero", sel_n, cur_resps[0]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_rr2();
        sel_n = 2;
        clear_inputs();
        req[0] = mk_req(32'h1000_0000, MLEN4);
        req[1] = mk_req(32'h2000_0010, MLEN4);
        gq.push_back(0); aq.push_back(req[0]);
        gq.push_back(1); aq.push_back(req[1]);
        gq.push_back(0); aq.push_back(req[0]);
        pulse_reset();
        test_bursts(3, 4, 60);
        n_tests++;
        if (first_cyc != 1) begin
            n_fail++;
            $display("FAIL rr2_latency: got %0d cycles, want 1", first_cyc);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_single4();
        sel_n = 4;
        clear_inputs();
        pulse_reset();
        @(negedge clk);
        req[3] = mk_req(32'h8000_0040, MLEN16);
        gq.push_back(3); aq.push_back(req[3]);
        test_bursts(1, 16, 40);
        n_tests++;
        if (first_cyc != 1) begin
            n_fail++;
            $display("FAIL single4_latency: got %0d cycles, want 1", first_cyc);
        end
        @(negedge clk);
        n_tests++;
        if (cur_busy !== 1'b0 || cur_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single4_done: busy=%b err=%b, want 0 0", cur_busy, cur_err);
        end
        clear_inputs();
    endtask

    task automatic test_rr3();
        sel_n = 3;
        clear_inputs();
        for (int i = 0; i < 3; i++) req[i] = mk_req(32'h4000_0000 + 32'h100 * i, MLEN1);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 3; i++) begin
                gq.push_back(i);
                aq.push_back(req[i]);
            end
        pulse_reset();
        test_bursts(9, 1, 80);
        @(negedge clk);
        clear_inputs();
    endtask

    // Early last on beat 2 of MLEN4 (errs_on_last=1) or an overrun on
    // MLEN1 (errs_on_last=0); either way port 0 gives up priority.
    task automatic test_bad_end(input bit errs_on_last);
        bit ok;
        sel_n = 2;
        clear_inputs();
        req[0] = mk_req(32'h3000_0000, errs_on_last ? MLEN4 : MLEN1);
        pulse_reset();
        wait_grant(10, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bad_end_grant: got no grant, want grant to port 0");
        end
        if (errs_on_last) begin
            oresp = mk_resp(1'b1, 1'b0, 32'h1);
            @(negedge clk);
            oresp = mk_resp(1'b1, 1'b1, 32'h2);
        end else begin
            oresp = mk_resp(1'b1, 1'b0, 32'h3);
        end
        @(negedge clk);
        oresp = '0;
        n_tests++;
        if (cur_err !== 1'b1 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_end_err(%0d): err=%b busy=%b, want 1 0", errs_on_last, cur_err, cur_busy);
        end
        req[0].valid = 1'b0;
        gq.push_back(1);
        @(negedge clk);
        n_tests++;
        if (cur_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_end_pulse(%0d): err=%b on 2nd cycle, want 0", errs_on_last, cur_err);
        end
        req[0].valid = 1'b1;
        req[1] = mk_req(32'h3000_1000, MLEN4);
        wait_grant(10, ok);
        n_tests++;
        if (!ok || cur_gid != gq.pop_front()) begin
            n_fail++;
            $display("FAIL bad_end_ptr(%0d): got grant_id=%0d ok=%b, want 1", errs_on_last, cur_gid, ok);
        end
        clear_inputs();
    endtask

    task automatic test_drop();
        bit ok;
        sel_n = 2;
        clear_inputs();
        req[0] = mk_req(32'h5000_0000, MLEN8);
        pulse_reset();
        wait_grant(10, ok);
        n_tests++;
        if (!ok || cur_gid != 0) begin
            n_fail++;
            $display("FAIL drop_grant: got grant_id=%0d ok=%b, want 0", cur_gid, ok);
        end
        oresp = mk_resp(1'b1, 1'b0, 32'h11);
        @(negedge clk);
        oresp = '0;
        req[0].valid = 1'b0;
        #1;
        n_tests++;
        if (cur_oreq.valid !== 1'b0 || cur_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_passthru: oreq.valid=%b busy=%b, want 0 1", cur_oreq.valid, cur_busy);
        end
        @(negedge clk);
        n_tests++;
        if (cur_err !== 1'b1 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_err: err=%b busy=%b, want 1 0", cur_err, cur_busy);
        end
        req[0].valid = 1'b1;
        req[1] = mk_req(32'h5000_1000, MLEN4);
        gq.push_back(0);
        wait_grant(10, ok);
        n_tests++;
        if (!ok || cur_gid != gq.pop_front() || cur_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_regrant: got grant_id=%0d err=%b ok=%b, want 0 0", cur_gid, cur_err, ok);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok, bad;
        sel_n = 4;
        clear_inputs();
        req[2] = mk_req(32'h6000_0000, MLEN8);
        pulse_reset();
        wait_grant(10, ok);
        n_tests++;
        if (!ok || cur_gid != 2) begin
            n_fail++;
            $display("FAIL rmid_grant: got grant_id=%0d ok=%b, want 2", cur_gid, ok);
        end
        oresp = mk_resp(1'b1, 1'b0, 32'h21);
        @(negedge clk);
        oresp = mk_resp(1'b1, 1'b0, 32'h22);
        @(negedge clk);
        oresp = mk_resp(1'b1, 1'b0, 32'h23);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        oresp = '0;
        req[1] = mk_req(32'h6000_1000, MLEN4);
        gq.push_back(1);
        #1;
        bad = 1'b0;
        for (int p = 0; p < MAXP; p++) if (cur_resps[p] !== '0) bad = 1'b1;
        n_tests++;
        if (cur_busy !== 1'b0 || cur_err !== 1'b0 || cur_oreq !== '0 || cur_gid != 0 || bad) begin
            n_fail++;
            $display("FAIL rmid_zero: busy=%b err=%b oreq=%h gid=%0d resps_bad=%b, want all 0", cur_busy, cur_err, cur_oreq, cur_gid, bad);
        end
        wait_grant(10, ok);
        n_tests++;
        if (!ok || cur_gid != gq.pop_front()) begin
            n_fail++;
            $display("FAIL rmid_regrant: got grant_id=%0d ok=%b, want 1", cur_gid, ok);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        sel_n = 2;
        clear_inputs();
        test_reset();
        test_rr2();
        test_single4();
        test_rr3();
        test_bad_end(1'b1);
        test_bad_end(1'b0);
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cbus_rr_arbiter.md
CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of upstream cbus masters; legal range 2..8.
REQ-002 Parameter SEL_W, default $clog2(NUM_PORTS), width of the port index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqs  input  NUM_PORTS x cbus_req_t  upstream burst requests, index 0..NUM_PORTS-1.
REQ-006 resps  output  NUM_PORTS x cbus_resp_t  upstream responses.
REQ-007 oreq  output  cbus_req_t  downstream burst request.
REQ-008 oresp  input  cbus_resp_t  downstream response.
REQ-009 grant_id  output  SEL_W  index of the port that owns the bus; meaningful only when busy=1.
REQ-010 busy  output  1  1 while a burst is owned by a port.
REQ-011 proto_err  output  1  one-cycle pulse on a burst protocol violation.

Function
REQ-012 States: IDLE, BUSY; the FSM resets to IDLE.
REQ-013 IDLE: oreq.valid=0, every resps[i]={ready 0, last 0, data 0}, busy=0.
REQ-014 IDLE with at least one reqs[i].valid: select the first valid port, scanning from prio_ptr upward modulo NUM_PORTS; latch it into grant_id; next state BUSY.
REQ-015 Grant latency: exactly 1 cycle from the request sampled in IDLE to oreq.valid=1.
REQ-016 BUSY: oreq = reqs[grant_id] (all fields passed through unmodified); resps[grant_id] = oresp; every other resps[j] = all zeros; busy=1.
REQ-017 A beat counter (8 bits) clears on entry to BUSY and increments on each cycle with oresp.ready=1.
REQ-018 BUSY with oresp.ready=1 and oresp.last=1: next state IDLE; prio_ptr <= (grant_id+1) mod NUM_PORTS.
REQ-019 When oresp.last=1 arrives with the beat counter != reqs[grant_id].len, pulse proto_err for 1 cycle; the burst still completes per REQ-018.
REQ-020 When oresp.ready=1 and oresp.last=0 arrive with the beat counter == reqs[grant_id].len (overrun), pulse proto_err for 1 cycle and force IDLE; prio_ptr advances as in REQ-018.
REQ-021 When reqs[grant_id].valid drops while BUSY: oreq.valid=0 on the same cycle (passthrough), pulse proto_err, and return to IDLE next cycle without advancing prio_ptr.
REQ-022 A request arriving on any port while BUSY is not dropped; it waits and is arbitrated on the next IDLE cycle.
REQ-023 After completion, at least one IDLE cycle separates consecutive bursts (no back-to-back grant).
REQ-024 Ports that hold valid continuously are served in strict round-robin; no port waits more than NUM_PORTS-1 bursts.
REQ-025 No combinational path from oresp to oreq.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, grant_id=0, prio_ptr=0, beat counter=0, proto_err=0, busy=0, oreq.valid=0, all resps zero, regardless of any burst in flight.
REQ-027 Reset asserted mid-burst abandons the burst; the first post-reset grant follows REQ-014 with prio_ptr=0.

Verification
REQ-028 NUM_PORTS=2, port0 and port1 both valid from reset release, each len=MLEN4 with 4 ready beats and last on the 4th -> port0 served first, then port1, then port0; grant_id sequence 0,1,0; each response routed only to the owner.
REQ-029 NUM_PORTS=4, only port 3 valid, addr 0x8000_0040, len MLEN16 -> oreq.valid 1 cycle after request; oreq.addr=0x8000_0040; 16 ready beats forwarded to resps[3]; resps[0..2] stay zero.
REQ-030 Burst len=MLEN4, downstream asserts last on beat 2 -> proto_err high exactly 1 cycle, FSM returns to IDLE, prio_ptr advanced.
REQ-031 Owner drops valid after 1 beat of 8 -> oreq.valid=0 the same cycle, proto_err pulse, IDLE next cycle, same port regains priority when it re-requests.
REQ-032 Reset pulsed for 1 cycle during beat 3 of a port2 burst -> next cycle busy=0, all outputs zero; with ports 1 and 2 valid, port1 granted first.
REQ-033 NUM_PORTS=3, all ports valid, 9 bursts of len MLEN1 -> grant_id 0,1,2,0,1,2,0,1,2; one IDLE cycle between bursts.
